// File: rtl/pokey_keyscan.sv
// Keyboard scan/debounce controller: walks the 6-bit matrix address, latches one
// key at a time through a 4-state debounce machine, and tracks CTRL/SHIFT/BREAK.
module pokey_keyscan #(
  parameter logic [5:0] MOD_CTRL  = 6'h00,
  parameter logic [5:0] MOD_SHIFT = 6'h10,
  parameter logic [5:0] MOD_BREAK = 6'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enp,
  input  logic       scan_en,
  input  logic       debounce_en,
  input  logic       kr1_n,
  input  logic       kr2_n,
  output logic [5:0] k,
  output logic [7:0] kbcode,
  output logic       key_down,
  output logic       shift_held,
  output logic       kbd_irq,
  output logic       break_irq
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] k_q, k_d;
  logic [5:0] stored_q, stored_d;
  logic [7:0] kbcode_q, kbcode_d;
  logic       ctrl_q, ctrl_d;
  logic       shift_q, shift_d;
  logic       brk_q, brk_d;
  logic       kbd_irq_q, kbd_irq_d;
  logic       brk_irq_q, brk_irq_d;

  logic match;
  logic pressed;

  assign match   = (k_q == stored_q);
  assign pressed = ~kr1_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      stored_q  <= '0;
      kbcode_q  <= '0;
      ctrl_q    <= 1'b0;
      shift_q   <= 1'b0;
      brk_q     <= 1'b0;
      kbd_irq_q <= 1'b0;
      brk_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stored_q  <= stored_d;
      kbcode_q  <= kbcode_d;
      ctrl_q    <= ctrl_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      kbd_irq_q <= kbd_irq_d;
      brk_irq_q <= brk_irq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    stored_d  = stored_q;
    kbcode_d  = kbcode_q;
    ctrl_d    = ctrl_q;
    shift_d   = shift_q;
    brk_d     = brk_q;
    kbd_irq_d = 1'b0;
    brk_irq_d = 1'b0;

    if (!scan_en) begin
      k_d     = '0;
      state_d = IDLE;
    end else if (enp) begin
      k_d = k_q + 6'd1;

      if (k_q == MOD_CTRL)  ctrl_d  = ~kr2_n;
      if (k_q == MOD_SHIFT) shift_d = ~kr2_n;
      if (k_q == MOD_BREAK) begin
        brk_d     = ~kr2_n;
        brk_irq_d = ~brk_q & ~kr2_n;
      end

      // Accepted codes use the modifier flags as held before this tick's update.
      case (state_q)
        IDLE: begin
          if (pressed) begin
            stored_d = k_q;
            if (debounce_en) begin
              state_d = DEBOUNCE;
            end else begin
              kbcode_d  = {ctrl_q, shift_q, k_q};
              kbd_irq_d = 1'b1;
              state_d   = HELD;
            end
          end
        end
        DEBOUNCE: begin
          if (match) begin
            if (pressed) begin
              kbcode_d  = {ctrl_q, shift_q, stored_q};
              kbd_irq_d = 1'b1;
              state_d   = HELD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (match && !pressed) state_d = debounce_en ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (match) state_d = pressed ? HELD : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign k          = k_q;
  assign kbcode     = kbcode_q;
  assign key_down   = (state_q == HELD) || (state_q == RELEASE);
  assign shift_held = shift_q;
  assign kbd_irq    = kbd_irq_q;
  assign break_irq  = brk_irq_q;

endmodule

// File: tb/tb_pokey_keyscan.sv
// Directed bench for pokey_keyscan: a bench-side key matrix answers each scan
// address, and hand-derived tick indices are checked for IRQs and codes.
module tb_pokey_keyscan;
  logic       clk = 1'b0;
  logic       rst_n, enp, scan_en, debounce_en, kr1_n, kr2_n;
  logic [5:0] k;
  logic [7:0] kbcode;
  logic       key_down, shift_held, kbd_irq, break_irq;

  int total = 0;
  int bad   = 0;
  logic [63:0] keys, mods;
  logic [5:0]  k_exp;
  int kirq_cnt, kirq_at, birq_cnt, birq_at, stray, ti;

  always #5 clk = ~clk;

  pokey_keyscan #(.MOD_CTRL(6'h00), .MOD_SHIFT(6'h10), .MOD_BREAK(6'h30)) dut (
    .clk(clk), .rst_n(rst_n), .enp(enp), .scan_en(scan_en),
    .debounce_en(debounce_en), .kr1_n(kr1_n), .kr2_n(kr2_n),
    .k(k), .kbcode(kbcode), .key_down(key_down), .shift_held(shift_held),
    .kbd_irq(kbd_irq), .break_irq(break_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One scan tick: enp for one edge, then an idle edge on which no IRQ may remain.
  task automatic tick();
    @(negedge clk);
    kr1_n = ~keys[k_exp];
    kr2_n = ~mods[k_exp];
    enp   = 1'b1;
    @(posedge clk);
    #1;
    if (kbd_irq === 1'b1)   begin kirq_cnt++; kirq_at = ti; end
    if (break_irq === 1'b1) begin birq_cnt++; birq_at = ti; end
    @(negedge clk);
    enp = 1'b0;
    @(posedge clk);
    #1;
    if (kbd_irq !== 1'b0 || break_irq !== 1'b0) stray++;
    if (scan_en) k_exp = k_exp + 6'd1;
    ti++;
  endtask

  task automatic run(input int n);
    ti = 0; kirq_cnt = 0; kirq_at = -1; birq_cnt = 0; birq_at = -1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; enp = 1'b0; scan_en = 1'b1; debounce_en = 1'b1;
    kr1_n = 1'b1; kr2_n = 1'b1; keys = '0; mods = '0; k_exp = '0; stray = 0;
    #12;
    chk("rst_k", k, 0);
    chk("rst_kbcode", kbcode, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_shift", shift_held, 0);
    chk("rst_kbd_irq", kbd_irq, 0);
    chk("rst_break_irq", break_irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    chk("post_rst_k", k, 5);
    chk("post_rst_irq", kirq_cnt + birq_cnt, 0);

    // Debounced press of 0x25 with SHIFT: first hit tick 32, accept tick 96
    mods[6'h10] = 1'b1;
    keys[6'h25] = 1'b1;
    run(96);
    chk("deb_no_irq_early", kirq_cnt, 0);
    chk("deb_kd_before", key_down, 0);
    chk("deb_k_at_hit", k, 6'h25);
    run(1);
    chk("deb_irq", kirq_cnt, 1);
    chk("deb_kbcode", kbcode, 8'h65);
    chk("deb_key_down", key_down, 1);
    run(95);
    chk("deb_single_irq", kirq_cnt, 0);
    chk("deb_held", key_down, 1);
    chk("deb_shift_held", shift_held, 1);

    // Release 0x25 over two passes, then a one-pass glitch at 0x12
    keys = '0;
    run(128);
    chk("rel_key_down", key_down, 0);
    keys[6'h12] = 1'b1;
    run(64);
    keys = '0;
    run(64);
    chk("glitch_no_irq", kirq_cnt, 0);
    chk("glitch_kbcode", kbcode, 8'h65);
    chk("glitch_key_down", key_down, 0);
    keys[6'h05] = 1'b1;
    run(65);
    chk("k05_irq", kirq_cnt, 1);
    chk("k05_irq_at", kirq_at, 64);
    chk("k05_kbcode", kbcode, 8'h45);

    // Drop SHIFT and release 0x05
    keys = '0; mods = '0;
    run(128);
    chk("clr_key_down", key_down, 0);
    chk("clr_shift", shift_held, 0);

    // Hold 0x25, add 0x07, release 0x25 over two passes, 0x07 then accepted
    keys[6'h25] = 1'b1;
    run(128);
    chk("h25_irq", kirq_cnt, 1);
    chk("h25_irq_at", kirq_at, 95);
    chk("h25_kbcode", kbcode, 8'h25);
    keys[6'h07] = 1'b1;
    run(64);
    chk("second_key_no_irq", kirq_cnt, 0);
    chk("second_key_kbcode", kbcode, 8'h25);
    keys[6'h25] = 1'b0;
    run(64);
    chk("release1_key_down", key_down, 1);
    run(64);
    chk("release2_key_down", key_down, 0);
    chk("release_no_irq", kirq_cnt, 0);
    run(66);
    chk("k07_irq", kirq_cnt, 1);
    chk("k07_irq_at", kirq_at, 65);
    chk("k07_kbcode", kbcode, 8'h07);

    // No debounce
    debounce_en = 1'b0;
    keys = '0;
    run(64);
    chk("nodeb_rel_key_down", key_down, 0);
    chk("nodeb_k", k, 6'h08);
    run(2);
    keys[6'h0A] = 1'b1;
    run(1);
    chk("nodeb_irq", kirq_cnt, 1);
    chk("nodeb_kbcode", kbcode, 8'h0A);
    chk("nodeb_key_down", key_down, 1);
    keys = '0;
    run(64);
    chk("nodeb_release", key_down, 0);
    chk("nodeb_no_irq", kirq_cnt, 0);

    // BREAK held for three passes
    mods[6'h30] = 1'b1;
    run(192);
    chk("break_cnt", birq_cnt, 1);
    chk("break_at", birq_at, 37);
    mods = '0;

    // Scan disable while HELD
    keys[6'h0A] = 1'b1;
    run(64);
    chk("held_irq", kirq_cnt, 1);
    chk("held_key_down", key_down, 1);
    @(negedge clk);
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    k_exp = '0;
    chk("dis_key_down", key_down, 0);
    chk("dis_k", k, 0);
    chk("dis_kbcode", kbcode, 8'h0A);
    chk("dis_irq", kbd_irq, 0);

    // Restart scanning, then assert reset between edges
    keys = '0;
    @(negedge clk);
    scan_en = 1'b1;
    run(3);
    chk("restart_k", k, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_k", k, 0);
    chk("async_rst_kbcode", kbcode, 0);
    chk("stray_irq_cycles", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end
endmodule
